stream_hs_monitor: RTL and testbench



---
 rtl/stream_hs_monitor.sv | 128 ++++++++++++
 tb/tb_stream_hs_monitor.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/stream_hs_monitor.sv
// Passive valid/ready stream monitor: transfer/stall statistics and sticky protocol error flags.
// Optional macro HSMON_DATA_CHK_EN builds the data-stability capture register and comparator.
module stream_hs_monitor #(
   parameter int DATA_W    = 8,
   parameter int CNT_W     = 16,
   parameter int STALL_W   = 8,
   parameter int MAX_STALL = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               clr,
   input  logic               valid,
   input  logic               ready,
   input  logic [DATA_W-1:0]  data,
   output logic [CNT_W-1:0]   xfer_cnt,
   output logic [STALL_W-1:0] cur_stall,
   output logic [STALL_W-1:0] max_stall,
   output logic               err_valid_drop,
   output logic               err_data_chg,
   output logic               err_timeout,
   output logic               err_any
);

   typedef enum logic {
      IDLE = 1'b0,
      PEND = 1'b1
   } state_t;

   localparam logic [STALL_W-1:0] STALL_SAT = '1;
   // A limit the stall counter can never reach leaves the timeout check inert.
   localparam bit TO_EN = (MAX_STALL > 0) &&
                          (longint'(MAX_STALL) < (longint'(1) << STALL_W));
   localparam logic [STALL_W-1:0] TO_LIM = STALL_W'(MAX_STALL);

   state_t             state, state_nx;
   logic [STALL_W-1:0] stall_nx;
   logic               xfer_ev, drop_ev, to_ev;

   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      state_nx = state;
      stall_nx = cur_stall;
      xfer_ev  = 1'b0;
      drop_ev  = 1'b0;
      case (state)
         IDLE: begin
            if (valid && ready) begin
               xfer_ev = 1'b1;
            end else if (valid) begin
               stall_nx = STALL_W'(1);
               state_nx = PEND;
            end
         end
         PEND: begin
            if (!valid) begin
               drop_ev  = 1'b1;
               stall_nx = '0;
               state_nx = IDLE;
            end else if (ready) begin
               xfer_ev  = 1'b1;
               stall_nx = '0;
               state_nx = IDLE;
            end else if (cur_stall != STALL_SAT) begin
               stall_nx = cur_stall + 1'b1;
            end
         end
      endcase
      to_ev = TO_EN && (stall_nx == TO_LIM) && (cur_stall != TO_LIM);
   end

   // Beat tracking ignores clr; only reset aborts a pending beat.
   // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         cur_stall <= '0;
      end else begin
         state     <= state_nx;
         cur_stall <= stall_nx;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         xfer_cnt       <= '0;
         max_stall      <= '0;
         err_valid_drop <= 1'b0;
         err_timeout    <= 1'b0;
      end else if (clr) begin
         xfer_cnt       <= '0;
         max_stall      <= '0;
         err_valid_drop <= 1'b0;
         err_timeout    <= 1'b0;
      end else begin
         if (xfer_ev)              xfer_cnt <= xfer_cnt + 1'b1;
         if (stall_nx > max_stall) max_stall <= stall_nx;
         if (drop_ev)              err_valid_drop <= 1'b1;
         if (to_ev)                err_timeout <= 1'b1;
      end
   end

`ifdef HSMON_DATA_CHK_EN
   logic [DATA_W-1:0] cap;
   logic              cap_ld, chg_ev;

   assign cap_ld = (state == IDLE) && valid && !ready;
   // The handshake cycle of a stalled beat is compared as well.
   assign chg_ev = (state == PEND) && valid && (data != cap);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cap          <= '0;
         err_data_chg <= 1'b0;
      end else begin
         if (cap_ld) cap <= data;
         if (clr)         err_data_chg <= 1'b0;
         else if (chg_ev) err_data_chg <= 1'b1;
      end
   end
`else
   logic unused_data;
   assign unused_data  = ^data;
   assign err_data_chg = 1'b0;
`endif

   assign err_any = err_valid_drop | err_data_chg | err_timeout;

endmodule

// File: tb/tb_stream_hs_monitor.sv
// Self-checking bench for stream_hs_monitor (MAX_STALL=4): vector table, directed corner
// sequences and a randomized run against a behavioural reference model.
module tb_stream_hs_monitor;

   localparam int DATA_W = 8, CNT_W = 16, STALL_W = 8, MAX_STALL = 4;
`ifdef HSMON_DATA_CHK_EN
   localparam bit CHK_EN = 1'b1;
`else
   localparam bit CHK_EN = 1'b0;
`endif

   logic               clk = 1'b0;
   logic               rst_n, clr, valid, ready;
   logic [DATA_W-1:0]  data;
   logic [CNT_W-1:0]   xfer_cnt;
   logic [STALL_W-1:0] cur_stall, max_stall;
   logic               err_valid_drop, err_data_chg, err_timeout, err_any;

   int tests = 0;
   int fails = 0;

   stream_hs_monitor #(
      .DATA_W(DATA_W), .CNT_W(CNT_W), .STALL_W(STALL_W), .MAX_STALL(MAX_STALL)
   ) dut (
      .clk(clk), .rst_n(rst_n), .clr(clr), .valid(valid), .ready(ready), .data(data),
      .xfer_cnt(xfer_cnt), .cur_stall(cur_stall), .max_stall(max_stall),
      .err_valid_drop(err_valid_drop), .err_data_chg(err_data_chg),
      .err_timeout(err_timeout), .err_any(err_any)
   );

   always #5 clk = ~clk;

   // Reference model: one pending beat at most, unbounded stall count, saturation applied on output.
   bit          m_pend;
   int          m_stall, m_xfers, m_max;
   logic [7:0]  m_pdata;
   bit          m_drop, m_chg, m_to;

   function automatic void model_reset();
      m_pend = 0; m_stall = 0; m_xfers = 0; m_max = 0; m_pdata = '0;
      m_drop = 0; m_chg = 0; m_to = 0;
   endfunction

   function automatic int shown_stall();
      return (m_stall > 255) ? 255 : m_stall;
   endfunction

   function automatic void model_step(input bit v, input bit r, input logic [7:0] d, input bit c);
      int  old_stall = m_stall;
      bit  ev_x = 0, ev_drop = 0, ev_chg = 0, ev_to;
      if (!m_pend) begin
         if (v && r) ev_x = 1;
         else if (v) begin m_pend = 1; m_pdata = d; m_stall = 1; end
      end else if (!v) begin
         ev_drop = 1; m_pend = 0; m_stall = 0;
      end else begin
         if (d != m_pdata) ev_chg = CHK_EN;
         if (r) begin ev_x = 1; m_pend = 0; m_stall = 0; end
         else m_stall = m_stall + 1;
      end
      ev_to = (MAX_STALL != 0) && (m_stall == MAX_STALL) && (old_stall != MAX_STALL);
      if (c) begin
         m_xfers = 0; m_max = 0; m_drop = 0; m_chg = 0; m_to = 0;
      end else begin
         m_xfers = m_xfers + int'(ev_x);
         if (shown_stall() > m_max) m_max = shown_stall();
         m_drop |= ev_drop; m_chg |= ev_chg; m_to |= ev_to;
      end
   endfunction

   function automatic logic [63:0] model_vec();
      logic [15:0] x = 16'(m_xfers % 65536);
      logic [7:0]  s = 8'(shown_stall());
      logic [7:0]  m = 8'(m_max);
      return 64'({x, s, m, m_drop, m_chg, m_to, m_drop | m_chg | m_to});
   endfunction

   function automatic logic [63:0] dut_vec();
      return 64'({xfer_cnt, cur_stall, max_stall, err_valid_drop, err_data_chg, err_timeout, err_any});
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Entered and left at posedge+1: drive, take one edge, update the model, settle.
   task automatic step(input bit v, input bit r, input logic [7:0] d, input bit c);
      valid = v; ready = r; data = d; clr = c;
      @(posedge clk);
      model_step(v, r, d, c);
      #1;
   endtask

   typedef struct {
      bit          v, r;
      logic [7:0]  d;
      bit          c;
      logic [15:0] xf;
      logic [7:0]  cs, ms;
      bit          ea;
   } vec_t;

   vec_t tbl[13];

   initial begin
      tbl[0]  = '{1, 1, 8'h11, 0, 16'd1, 8'd0, 8'd0, 0};
      tbl[1]  = '{1, 1, 8'h22, 0, 16'd2, 8'd0, 8'd0, 0};
      tbl[2]  = '{1, 1, 8'h33, 0, 16'd3, 8'd0, 8'd0, 0};
      tbl[3]  = '{0, 0, 8'h00, 0, 16'd3, 8'd0, 8'd0, 0};
      tbl[4]  = '{0, 0, 8'h00, 1, 16'd0, 8'd0, 8'd0, 0};
      tbl[5]  = '{1, 0, 8'hA5, 0, 16'd0, 8'd1, 8'd1, 0};
      tbl[6]  = '{1, 0, 8'hA5, 0, 16'd0, 8'd2, 8'd2, 0};
      tbl[7]  = '{1, 0, 8'hA5, 0, 16'd0, 8'd3, 8'd3, 0};
      tbl[8]  = '{1, 1, 8'hA5, 0, 16'd1, 8'd0, 8'd3, 0};
      tbl[9]  = '{0, 1, 8'h00, 0, 16'd1, 8'd0, 8'd3, 0};
      tbl[10] = '{1, 1, 8'h44, 1, 16'd0, 8'd0, 8'd0, 0};
      tbl[11] = '{1, 1, 8'h55, 0, 16'd1, 8'd0, 8'd0, 0};
      tbl[12] = '{0, 0, 8'h00, 0, 16'd1, 8'd0, 8'd0, 0};

      rst_n = 1'b0; clr = 1'b0; valid = 1'b0; ready = 1'b0; data = '0;
      model_reset();
      #12;
      check("reset_outputs", dut_vec(), 64'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      for (int i = 0; i < 13; i++) begin
         step(tbl[i].v, tbl[i].r, tbl[i].d, tbl[i].c);
         check($sformatf("tbl%0d.xfer", i),  64'(xfer_cnt),  64'(tbl[i].xf));
         check($sformatf("tbl%0d.stall", i), 64'(cur_stall), 64'(tbl[i].cs));
         check($sformatf("tbl%0d.max", i),   64'(max_stall), 64'(tbl[i].ms));
         check($sformatf("tbl%0d.err", i),   64'(err_any),   64'(tbl[i].ea));
      end

      // Timeout at the 4th stall edge, then saturation at 255.
      step(0, 0, 8'h00, 1);
      for (int k = 1; k <= 300; k++) begin
         step(1, 0, 8'h3C, 0);
         if (k == 3) begin
            check("to_before.timeout", 64'(err_timeout), 64'd0);
            check("to_before.stall",   64'(cur_stall),   64'd3);
         end
         if (k == 4) begin
            check("to_hit.timeout", 64'(err_timeout), 64'd1);
            check("to_hit.err_any", 64'(err_any),     64'd1);
         end
         if (k == 255) check("sat_reach.stall", 64'(cur_stall), 64'd255);
      end
      check("sat_hold.stall", 64'(cur_stall), 64'd255);
      check("sat_hold.max",   64'(max_stall), 64'd255);
      step(1, 1, 8'h3C, 0);
      check("sat_accept.xfer",    64'(xfer_cnt),    64'd1);
      check("sat_accept.stall",   64'(cur_stall),   64'd0);
      check("sat_accept.timeout", 64'(err_timeout), 64'd1);

      // Data change while pending, then valid drop, then clear.
      step(0, 0, 8'h00, 1);
      check("clr1.all", dut_vec(), 64'd0);
      step(1, 0, 8'hA5, 0);
      step(1, 0, 8'h5A, 0);
      check("dchg.flag",    64'(err_data_chg), 64'(CHK_EN));
      check("dchg.err_any", 64'(err_any),      64'(CHK_EN));
      step(0, 0, 8'h00, 0);
      check("drop.flag",  64'(err_valid_drop), 64'd1);
      check("drop.stall", 64'(cur_stall),      64'd0);
      step(1, 0, 8'h77, 1);
      check("clr2.err_any", 64'(err_any),   64'd0);
      check("clr2.xfer",    64'(xfer_cnt),  64'd0);
      check("clr2.max",     64'(max_stall), 64'd0);
      check("clr2.stall",   64'(cur_stall), 64'd1);
      step(1, 0, 8'h77, 0);
      check("recap.stall", 64'(cur_stall),    64'd2);
      check("recap.dchg",  64'(err_data_chg), 64'd0);

      // Asynchronous reset mid-beat (cur_stall=2).
      #1 rst_n = 1'b0;
      #1 check("async_rst.all", dut_vec(), 64'd0);
      model_reset();
      valid = 1'b0;
      #2 rst_n = 1'b1;
      step(0, 0, 8'h00, 0);
      step(1, 0, 8'h77, 0);
      check("post_rst.stall",   64'(cur_stall), 64'd1);
      check("post_rst.err_any", 64'(err_any),   64'd0);

      // Randomized traffic against the reference model.
      for (int n = 0; n < 2000; n++) begin
         bit         v, r, c;
         logic [7:0] d;
         v = ($urandom_range(99) < 75);
         r = ($urandom_range(99) < 45);
         c = ($urandom_range(99) < 3);
         d = ($urandom_range(99) < 85) ? data : 8'($urandom);
         step(v, r, d, c);
         check($sformatf("rand%0d", n), dut_vec(), model_vec());
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
